// File: rtl/rom_stream_reader_pkg.sv
// rtl/rom_stream_reader_pkg.sv - shared width helpers for the ROM stream reader
package rom_stream_reader_pkg;

    localparam int TLAST_W = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Each response entry carries the ROM word plus its tlast sideband bit.
    function automatic int entry_width(input int data_width);
        return data_width + TLAST_W;
    endfunction

endpackage

// File: rtl/rom_stream_reader_if.sv
// rtl/rom_stream_reader_if.sv - address stream, response stream and ROM port bundle
interface rom_stream_reader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic                  s_axis_tlast;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
    logic                  rom_en;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic                  rom_ack;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready, rom_data, rom_ack,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, rom_en, rom_addr
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready, rom_data, rom_ack,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, rom_en, rom_addr
    );
endinterface

// File: rtl/rom_resp_fifo.sv
// rtl/rom_resp_fifo.sv - synchronous response FIFO with explicit pointer wrap
module rom_resp_fifo
    import rom_stream_reader_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 9,
    localparam int PW    = clog2(DEPTH),
    localparam int CW    = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Wrap at DEPTH-1 so non-power-of-two depths stay in range.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= din;
    end

    assign dout  = mem[rd_ptr_q];
    assign count = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/rom_stream_reader.sv
// rtl/rom_stream_reader.sv - address stream to ROM reads, responses re-streamed in order
module rom_stream_reader
    import rom_stream_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    rom_stream_reader_if.slave   bus
);

    localparam int EW = entry_width(DATA_WIDTH);
    localparam int CW = clog2(FIFO_DEPTH + 1);

    logic                  released_q, released_d;
    logic                  pending_q, pending_d;
    logic                  last_q, last_d;
    logic [CW-1:0]         count;
    logic                  s_ready, accept, wr_en, rd_en, m_valid;
    logic [EW-1:0]         din, dout;
    logic [ADDR_WIDTH-1:0] addr;

    // Credit check counts the in-flight read so its response always has a slot.
    always_comb begin
        released_d = 1'b1;
        m_valid    = (count != '0);
        s_ready    = released_q
                     && (({1'b0, count} + (CW+1)'(pending_q)) < (CW+1)'(FIFO_DEPTH));
        accept     = bus.s_axis_tvalid && s_ready;
        pending_d  = accept;
        last_d     = accept ? bus.s_axis_tlast : last_q;
        wr_en      = bus.rom_ack && pending_q;
        din        = {last_q, bus.rom_data};
        rd_en      = m_valid && bus.m_axis_tready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            released_q <= 1'b0;
            pending_q  <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            released_q <= released_d;
            pending_q  <= pending_d;
            last_q     <= last_d;
        end
    end

    rom_resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (wr_en),
        .din   (din),
        .rd_en (rd_en),
        .dout  (dout),
        .count (count)
    );

    assign addr              = bus.s_axis_tdata;
    assign bus.rom_addr      = addr;
    assign bus.rom_en        = accept;
    assign bus.s_axis_tready = s_ready;
    assign bus.m_axis_tvalid = m_valid;
    assign bus.m_axis_tdata  = dout[DATA_WIDTH-1:0];
    assign bus.m_axis_tlast  = dout[EW-1];

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb/tb_rom_stream_reader.sv - bench for rom_stream_reader
module tb_rom_stream_reader;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } exp_t;

    typedef struct {
        logic [7:0]  addr;
        logic        last;
        logic [15:0] exp_d;
        logic        exp_l;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic inj_ack = 1'b0;
    always #5 clk = ~clk;

    rom_stream_reader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) if0 ();
    rom_stream_reader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) if1 ();

    rom_stream_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .FIFO_DEPTH(4)) u0 (
        .clk (clk), .rst_n (rst_n), .bus (if0)
    );
    rom_stream_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .FIFO_DEPTH(2)) u1 (
        .clk (clk), .rst_n (rst_n), .bus (if1)
    );

    logic [15:0] rom_img [256];

    always_ff @(posedge clk) begin
        if0.rom_ack <= if0.rom_en | inj_ack;
        if (if0.rom_en) if0.rom_data <= rom_img[if0.rom_addr];
        if1.rom_ack <= if1.rom_en;
        if (if1.rom_en) if1.rom_data <= rom_img[if1.rom_addr];
    end

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_acc, n_out, acc_first, acc_last, out_first, out_last, idx;
    bit   sel = 1'b0;
    bit   mon_en = 1'b0;
    bit   rdy_rand = 1'b0;
    exp_t expq[$];
    exp_t e;
    vec_t vecs[5];

    logic        s_v, s_r, s_l, s_en, m_v, m_r, m_l, acc_seen;
    logic [7:0]  s_d, rom_a;
    logic [15:0] m_d;
    logic        hold_v = 1'b0;
    logic [15:0] hold_d;
    logic        hold_l;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic sdrive(input logic v, input logic [7:0] a, input logic l);
        if (sel == 1'b0) begin
            if0.s_axis_tvalid = v; if0.s_axis_tdata = a; if0.s_axis_tlast = l;
        end else begin
            if1.s_axis_tvalid = v; if1.s_axis_tdata = a; if1.s_axis_tlast = l;
        end
    endtask

    task automatic set_mrdy(input logic r);
        if (sel == 1'b0) if0.m_axis_tready = r;
        else             if1.m_axis_tready = r;
    endtask

    task automatic clear_stats();
        n_acc = 0; n_out = 0; acc_first = 0; acc_last = 0; out_first = 0; out_last = 0;
        hold_v = 1'b0;
        expq.delete();
    endtask

    // Reference: output order equals accept order, each word = rom_img[addr] with its tlast.
    task automatic monitor();
        if (sel == 1'b0) begin
            s_v = if0.s_axis_tvalid; s_r = if0.s_axis_tready; s_l = if0.s_axis_tlast;
            s_d = if0.s_axis_tdata;  s_en = if0.rom_en;       rom_a = if0.rom_addr;
            m_v = if0.m_axis_tvalid; m_r = if0.m_axis_tready; m_l = if0.m_axis_tlast;
            m_d = if0.m_axis_tdata;
        end else begin
            s_v = if1.s_axis_tvalid; s_r = if1.s_axis_tready; s_l = if1.s_axis_tlast;
            s_d = if1.s_axis_tdata;  s_en = if1.rom_en;       rom_a = if1.rom_addr;
            m_v = if1.m_axis_tvalid; m_r = if1.m_axis_tready; m_l = if1.m_axis_tlast;
            m_d = if1.m_axis_tdata;
        end
        acc_seen = s_v && s_r;
        if (!mon_en) begin
            hold_v = 1'b0;
            return;
        end
        if (acc_seen) begin
            if (n_acc == 0) acc_first = cyc;
            acc_last = cyc;
            n_acc++;
            expq.push_back({rom_img[s_d], s_l});
        end
        if (hold_v) begin
            chk("stall_valid", m_v, 1);
            chk("stall_data", m_d, hold_d);
            chk("stall_last", m_l, hold_l);
        end
        if (m_v && m_r) begin
            if (expq.size() == 0) begin
                chk("unexpected_output", 0, 1);
            end else begin
                e = expq.pop_front();
                chk("out_data", m_d, e.d);
                chk("out_last", m_l, e.l);
            end
            if (n_out == 0) out_first = cyc;
            out_last = cyc;
            n_out++;
        end
        hold_v = m_v && !m_r;
        hold_d = m_d;
        hold_l = m_l;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        if (rdy_rand) set_mrdy(1'($urandom_range(0, 1)));
    endtask

    task automatic send(input logic [7:0] a, input logic l, input bit gaps);
        int g;
        if (gaps) begin
            while ($urandom_range(0, 1) == 1) begin
                sdrive(1'b0, a, l);
                tick();
            end
        end
        sdrive(1'b1, a, l);
        g = 0;
        do begin
            tick();
            g++;
        end while (!acc_seen && g < 100);
        chk("accept_wait", acc_seen, 1);
    endtask

    task automatic drain();
        int g;
        g = 0;
        sdrive(1'b0, 8'd0, 1'b0);
        while (expq.size() != 0 && g < 400) begin
            tick();
            g++;
        end
        chk("drain_empty", expq.size(), 0);
    endtask

    initial begin
        vecs[0] = '{8'd0,   1'b1, 16'd0,   1'b1};
        vecs[1] = '{8'd5,   1'b0, 16'd15,  1'b0};
        vecs[2] = '{8'd85,  1'b1, 16'd255, 1'b1};
        vecs[3] = '{8'd255, 1'b1, 16'd765, 1'b1};
        vecs[4] = '{8'd128, 1'b0, 16'd384, 1'b0};
        for (int a = 0; a < 256; a++) rom_img[a] = 16'(a * 3);

        sel = 1'b1; sdrive(1'b0, 8'd0, 1'b0); if1.m_axis_tready = 1'b1;
        sel = 1'b0; sdrive(1'b1, 8'h12, 1'b0); if0.m_axis_tready = 1'b1;

        // Reset state and one-cycle release delay on s_axis_tready.
        tick(); tick();
        chk("reset_tready", s_r, 0);
        chk("reset_tvalid", m_v, 0);
        chk("reset_rom_en", s_en, 0);
        rst_n = 1'b1;
        tick();
        chk("release_tready_early", s_r, 0);
        chk("release_rom_en_early", s_en, 0);
        tick();
        chk("release_tready", s_r, 1);
        chk("release_rom_en", s_en, 1);
        chk("release_rom_addr", rom_a, 8'h12);
        sdrive(1'b0, 8'd0, 1'b0);
        repeat (4) tick();

        // Single-beat vectors: latency of exactly two cycles.
        for (int i = 0; i < 5; i++) begin
            sdrive(1'b1, vecs[i].addr, vecs[i].last);
            tick();
            chk("vec_accept", acc_seen, 1);
            sdrive(1'b0, 8'd0, 1'b0);
            tick();
            chk("vec_early_valid", m_v, 0);
            tick();
            chk("vec_valid", m_v, 1);
            chk("vec_data", m_d, vecs[i].exp_d);
            chk("vec_last", m_l, vecs[i].exp_l);
            tick();
            chk("vec_empty", m_v, 0);
        end

        // Streaming at full rate.
        clear_stats(); mon_en = 1'b1;
        for (int i = 0; i < 16; i++) send(8'(i), (i == 15), 1'b0);
        drain();
        chk("t1_accept_span", acc_last - acc_first, 15);
        chk("t1_first_latency", out_first - acc_first, 2);
        chk("t1_total_span", out_last - acc_first, 17);
        chk("t1_nout", n_out, 16);

        // Backpressure: four credits, then resume.
        clear_stats(); set_mrdy(1'b0);
        idx = 0; sdrive(1'b1, 8'd0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            tick();
            if (acc_seen) begin
                idx++;
                sdrive(1'b1, 8'(idx), (idx == 15));
            end
        end
        chk("t2_accepts", n_acc, 4);
        chk("t2_tready_low", s_r, 0);
        set_mrdy(1'b1);
        while (idx < 16) begin
            send(8'(idx), (idx == 15), 1'b0);
            idx++;
        end
        drain();
        chk("t2_nout", n_out, 16);

        // Random valid/ready against random ROM contents.
        for (int a = 0; a < 256; a++) rom_img[a] = 16'($urandom);
        clear_stats(); rdy_rand = 1'b1;
        for (int i = 0; i < 1000; i++) send(8'($urandom), ($urandom_range(0, 7) == 0), 1'b1);
        drain();
        rdy_rand = 1'b0; set_mrdy(1'b1);
        chk("t3_nout", n_out, 1000);

        // Push and pop together while three words are buffered.
        clear_stats(); set_mrdy(1'b0);
        send(8'd10, 1'b0, 1'b0); send(8'd11, 1'b0, 1'b0); send(8'd12, 1'b0, 1'b0);
        sdrive(1'b0, 8'd0, 1'b0);
        tick(); tick();
        chk("t4_ready_at_3", s_r, 1);
        chk("t4_valid_at_3", m_v, 1);
        sdrive(1'b1, 8'd13, 1'b1);
        tick();
        chk("t4_accept", acc_seen, 1);
        sdrive(1'b0, 8'd0, 1'b0); set_mrdy(1'b1);
        tick();
        chk("t4_no_credit", s_r, 0);
        chk("t4_pop", m_v && m_r, 1);
        set_mrdy(1'b0);
        tick();
        chk("t4_count_kept", s_r, 1);
        set_mrdy(1'b1);
        drain();
        chk("t4_nout", n_out, 4);

        // Reset with three words buffered and one read in flight.
        clear_stats(); set_mrdy(1'b0);
        for (int i = 0; i < 4; i++) send(8'(20 + i), 1'b0, 1'b0);
        sdrive(1'b0, 8'd0, 1'b0);
        chk("t5_pre_valid", if0.m_axis_tvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", if0.m_axis_tvalid, 0);
        chk("t5_rst_tready", if0.s_axis_tready, 0);
        mon_en = 1'b0; clear_stats();
        tick();
        rst_n = 1'b1; inj_ack = 1'b1;
        tick();
        inj_ack = 1'b0;
        chk("t5_tready_early", s_r, 0);
        tick();
        chk("t5_tready", s_r, 1);
        chk("t5_no_valid", m_v, 0);
        tick();
        chk("t5_stale_ack_ignored", m_v, 0);
        mon_en = 1'b1; set_mrdy(1'b1);
        for (int i = 0; i < 3; i++) send(8'(40 + i), (i == 2), 1'b0);
        drain();
        chk("t5_nout", n_out, 3);

        // Two-entry FIFO: correct data, below one beat per cycle.
        sel = 1'b1; clear_stats(); set_mrdy(1'b1);
        for (int i = 0; i < 8; i++) send(8'(i * 7), (i == 7), 1'b0);
        drain();
        chk("t6_nout", n_out, 8);
        chk("t6_rate", (acc_last - acc_first > 7) && (acc_last - acc_first <= 14), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
